// File: rtl/fp32_ddot_stream.sv
// fp32_ddot_stream: streaming FP32 dot product, LANES products per beat, pairwise
// tree reduction, beat accumulation until in_last, one scalar result per vector.
// Arithmetic is round-toward-zero with denormals flushed to signed zero.
// Optional status output flags[2:0] = {nan, ovf, ftz} when DDOT_STATUS_EN is defined.
module fp32_ddot_stream #(
    parameter int LANES = 4,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  logic                  in_last,
    input  logic [32*LANES-1:0]   x_flat,
    input  logic [32*LANES-1:0]   y_flat,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [31:0]           z,
    output logic [CNT_W-1:0]      beats
`ifdef DDOT_STATUS_EN
    ,
    output logic [2:0]            flags
`endif
);

    localparam logic [31:0] QNAN = 32'h7FC00000;

    typedef enum logic [1:0] {IDLE, ACC, HOLD} st_t;

    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        logic [24:0] ph;
        logic [9:0]  e;
        logic [22:0] m;
        s      = a[31] ^ b[31];
        a_nan  = (&a[30:23]) & (|a[22:0]);
        b_nan  = (&b[30:23]) & (|b[22:0]);
        a_inf  = (&a[30:23]) & ~(|a[22:0]);
        b_inf  = (&b[30:23]) & ~(|b[22:0]);
        a_zero = ~(|a[30:23]);
        b_zero = ~(|b[30:23]);
        ph = 25'(({24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]}) >> 23);
        e  = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127 + {9'd0, ph[24]};
        m  = ph[24] ? ph[23:1] : ph[22:0];
        if (a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero)) return QNAN;
        if (a_inf | b_inf) return {s, 8'hFF, 23'd0};
        if (a_zero | b_zero) return {s, 31'd0};
        if (!e[9] && e >= 10'd255) return {s, 8'hFF, 23'd0};
        if (e[9] || e == 10'd0) return {s, 31'd0};
        return {s, e[7:0], m};
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        logic [31:0] big, sml;
        logic [7:0]  d;
        logic [26:0] mb, ms0, ms, mask;
        logic [27:0] r;
        logic [9:0]  e;
        a_nan  = (&a[30:23]) & (|a[22:0]);
        b_nan  = (&b[30:23]) & (|b[22:0]);
        a_inf  = (&a[30:23]) & ~(|a[22:0]);
        b_inf  = (&b[30:23]) & ~(|b[22:0]);
        a_zero = ~(|a[30:23]);
        b_zero = ~(|b[30:23]);
        if (a_nan | b_nan | (a_inf & b_inf & (a[31] ^ b[31]))) return QNAN;
        if (a_inf) return {a[31], 8'hFF, 23'd0};
        if (b_inf) return {b[31], 8'hFF, 23'd0};
        if (a_zero & b_zero) return {a[31] & b[31], 31'd0};
        if (a_zero) return b;
        if (b_zero) return a;
        big  = (b[30:0] > a[30:0]) ? b : a;
        sml  = (b[30:0] > a[30:0]) ? a : b;
        d    = big[30:23] - sml[30:23];
        mb   = {1'b1, big[22:0], 3'b000};
        ms0  = {1'b1, sml[22:0], 3'b000};
        mask = (27'd1 << d) - 27'd1;
        ms   = (d >= 8'd27) ? 27'd1 : ((ms0 >> d) | {26'd0, |(ms0 & mask)});
        r    = (big[31] == sml[31]) ? ({1'b0, mb} + {1'b0, ms}) : ({1'b0, mb} - {1'b0, ms});
        e    = {2'b0, big[30:23]};
        if (r == 28'd0) return 32'd0;
        if (r[27]) begin
            r = {1'b0, r[27:2], r[1] | r[0]};
            e = e + 10'd1;
        end
        for (int i = 0; i < 27; i++) begin
            if (!r[26]) begin
                r = r << 1;
                e = e - 10'd1;
            end
        end
        if (!e[9] && e >= 10'd255) return {big[31], 8'hFF, 23'd0};
        if (e[9] || e == 10'd0) return {big[31], 31'd0};
        return {big[31], e[7:0], r[25:3]};
    endfunction

    logic              adv;
    logic              first_q, first_d;
    logic              v1_q, v1_d, f1_q, f1_d, l1_q, l1_d;
    logic [31:0]       prod [LANES];
    logic [31:0]       p_q  [LANES];
    logic [31:0]       p_d  [LANES];
    logic [31:0]       t    [2*LANES-1];
    logic              v2_q, v2_d, f2_q, f2_d, l2_q, l2_d;
    logic [31:0]       part_q, part_d;
    logic [31:0]       acc_q, acc_d, sum;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_nx;
    logic [31:0]       z_q, z_d;
    logic [CNT_W-1:0]  beats_q, beats_d;
    logic              out_vld_q, out_vld_d;
    logic              ld;
    st_t               state_q, state_d, ret_q, ret_d, base;

    assign adv     = ~out_vld_q | out_rdy;
    assign in_rdy  = adv;
    assign out_vld = out_vld_q;
    assign z       = z_q;
    assign beats   = beats_q;

    // S1: lane products and beat tags; first marks the beat after reset or after a last beat
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            prod[i] = fp_mul(x_flat[32*i +: 32], y_flat[32*i +: 32]);
            p_d[i]  = adv ? prod[i] : p_q[i];
        end
        first_d = (adv & in_vld) ? in_last : first_q;
        v1_d    = adv ? in_vld  : v1_q;
        f1_d    = adv ? first_q : f1_q;
        l1_d    = adv ? in_last : l1_q;
    end

    // S2: pairwise adder tree in heap order so leaves combine as ((p0+p1)+(p2+p3))...
    always_comb begin
        for (int i = 0; i < 2*LANES-1; i++) t[i] = 32'd0;
        for (int i = 0; i < LANES; i++) t[LANES-1+i] = p_q[i];
        for (int i = LANES-2; i >= 0; i--) t[i] = fp_add(t[2*i+1], t[2*i+2]);
        part_d = adv ? t[0] : part_q;
        v2_d   = adv ? v1_q : v2_q;
        f2_d   = adv ? f1_q : f2_q;
        l2_d   = adv ? l1_q : l2_q;
    end

    // S3: accumulate partials, count beats, deliver the result on the last beat
    always_comb begin
        ld        = adv & v2_q;
        sum       = f2_q ? part_q : fp_add(acc_q, part_q);
        cnt_nx    = f2_q ? CNT_W'(1) : ((&cnt_q) ? cnt_q : cnt_q + CNT_W'(1));
        acc_d     = ld ? (l2_q ? 32'd0 : sum) : acc_q;
        cnt_d     = ld ? cnt_nx : cnt_q;
        z_d       = (ld & l2_q) ? sum : z_q;
        beats_d   = (ld & l2_q) ? cnt_nx : beats_q;
        out_vld_d = adv ? (v2_q & l2_q) : out_vld_q;
    end

    // S3 state: IDLE/ACC follow the accumulator, HOLD while the consumer stalls
    always_comb begin
        base    = (state_q == HOLD) ? ret_q : state_q;
        ret_d   = (state_q == HOLD) ? ret_q : state_q;
        state_d = !adv ? HOLD : (v2_q ? (l2_q ? IDLE : ACC) : base);
    end

    // Pipeline, accumulator, output and state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            first_q   <= 1'b1;
            v1_q      <= 1'b0;
            f1_q      <= 1'b0;
            l1_q      <= 1'b0;
            for (int i = 0; i < LANES; i++) p_q[i] <= 32'd0;
            v2_q      <= 1'b0;
            f2_q      <= 1'b0;
            l2_q      <= 1'b0;
            part_q    <= 32'd0;
            acc_q     <= 32'd0;
            cnt_q     <= '0;
            z_q       <= 32'd0;
            beats_q   <= '0;
            out_vld_q <= 1'b0;
            state_q   <= IDLE;
            ret_q     <= IDLE;
        end else begin
            first_q   <= first_d;
            v1_q      <= v1_d;
            f1_q      <= f1_d;
            l1_q      <= l1_d;
            for (int i = 0; i < LANES; i++) p_q[i] <= p_d[i];
            v2_q      <= v2_d;
            f2_q      <= f2_d;
            l2_q      <= l2_d;
            part_q    <= part_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            z_q       <= z_d;
            beats_q   <= beats_d;
            out_vld_q <= out_vld_d;
            state_q   <= state_d;
            ret_q     <= ret_d;
        end
    end

`ifdef DDOT_STATUS_EN
    function automatic logic [2:0] fp_flags(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] r, input logic add);
        logic a_inf, b_inf, a_dn, b_dn, a_zero, b_zero;
        a_inf  = (&a[30:23]) & ~(|a[22:0]);
        b_inf  = (&b[30:23]) & ~(|b[22:0]);
        a_zero = ~(|a[30:23]);
        b_zero = ~(|b[30:23]);
        a_dn   = a_zero & (|a[22:0]);
        b_dn   = b_zero & (|b[22:0]);
        return {(&r[30:23]) & (|r[22:0]),
                (&r[30:23]) & ~(|r[22:0]) & ~a_inf & ~b_inf,
                a_dn | b_dn | (~(|r[30:23]) & ~a_zero & ~b_zero & ~(add & (a[30:0] == b[30:0])))};
    endfunction

    logic [2:0] fl1_q, fl1_d, fl2_q, fl2_d, accfl_q, accfl_d, flags_q, flags_d, sumfl;
    logic [2:0] tf [2*LANES-1];

    assign flags = flags_q;

    // Sticky status follows each beat through the pipe and merges into the vector result
    always_comb begin
        fl1_d = 3'b000;
        for (int i = 0; i < LANES; i++)
            fl1_d = fl1_d | fp_flags(x_flat[32*i +: 32], y_flat[32*i +: 32], prod[i], 1'b0);
        fl1_d = adv ? fl1_d : fl1_q;
        for (int i = 0; i < 2*LANES-1; i++) tf[i] = 3'b000;
        for (int i = 0; i < LANES; i++) tf[LANES-1+i] = fl1_q;
        for (int i = LANES-2; i >= 0; i--)
            tf[i] = tf[2*i+1] | tf[2*i+2] | fp_flags(t[2*i+1], t[2*i+2], t[i], 1'b1);
        fl2_d   = adv ? tf[0] : fl2_q;
        sumfl   = fl2_q | (f2_q ? 3'b000 : (accfl_q | fp_flags(acc_q, part_q, sum, 1'b1)));
        accfl_d = ld ? (l2_q ? 3'b000 : sumfl) : accfl_q;
        flags_d = (ld & l2_q) ? sumfl : flags_q;
    end

    // Status registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fl1_q   <= 3'b000;
            fl2_q   <= 3'b000;
            accfl_q <= 3'b000;
            flags_q <= 3'b000;
        end else begin
            fl1_q   <= fl1_d;
            fl2_q   <= fl2_d;
            accfl_q <= accfl_d;
            flags_q <= flags_d;
        end
    end
`endif

endmodule

// File: tb/tb_fp32_ddot_stream.sv
// tb_fp32_ddot_stream: directed scoreboard bench for fp32_ddot_stream (LANES=4).
module tb_fp32_ddot_stream;

    localparam int LANES = 4;
    localparam int CNT_W = 16;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                in_vld = 1'b0;
    logic                in_rdy;
    logic                in_last = 1'b0;
    logic [32*LANES-1:0] x_flat = '0;
    logic [32*LANES-1:0] y_flat = '0;
    logic                out_vld;
    logic                out_rdy = 1'b1;
    logic [31:0]         z;
    logic [CNT_W-1:0]    beats;
`ifdef DDOT_STATUS_EN
    logic [2:0]          flags;
`endif

    int checks = 0;
    int errors = 0;
    int stall;
    logic [47:0] sb [$];

    localparam logic [127:0] ONES = {4{32'h3F800000}};
    localparam logic [127:0] TWOS = {4{32'h40000000}};

    fp32_ddot_stream #(.LANES(LANES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .in_last(in_last),
        .x_flat(x_flat), .y_flat(y_flat), .out_vld(out_vld), .out_rdy(out_rdy),
        .z(z), .beats(beats)
`ifdef DDOT_STATUS_EN
        , .flags(flags)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [127:0] x, input logic [127:0] y, input logic last);
        in_vld  = 1'b1;
        x_flat  = x;
        y_flat  = y;
        in_last = last;
        stall   = 0;
        @(negedge clk);
        while (!in_rdy && stall < 200) begin
            @(negedge clk);
            stall++;
        end
        if (stall >= 200) begin
            checks++;
            errors++;
            $error("FAIL rdy_timeout observed=%0d expected<200", stall);
        end
        @(posedge clk);
        #1;
        in_vld = 1'b0;
    endtask

    task automatic vec1(input logic [127:0] x, input logic [127:0] y, input logic [31:0] exp);
        sb.push_back({exp, 16'd1});
        drive(x, y, 1'b1);
    endtask

    always @(negedge clk) begin
        if (rst && out_vld && out_rdy) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_result observed=%h expected=none", z);
            end else begin
                logic [47:0] e;
                e = sb.pop_front();
                chk("sb_z", z, e[47:16]);
                chk("sb_beats", {16'd0, beats}, {16'd0, e[15:0]});
            end
        end
    end

    initial begin
        int n;
        repeat (2) @(negedge clk);
        chk("rst_out_vld", {31'd0, out_vld}, 32'd0);
        chk("rst_z", z, 32'd0);
        chk("rst_beats", {16'd0, beats}, 32'd0);
        sync();
        rst = 1'b1;

        vec1(ONES, ONES, 32'h40800000);
        @(negedge clk);
        chk("lat_e0", {31'd0, out_vld}, 32'd0);
        @(negedge clk);
        chk("lat_e1", {31'd0, out_vld}, 32'd0);
        @(negedge clk);
        chk("lat_e2", {31'd0, out_vld}, 32'd1);

        sync();
        sb.push_back({32'h42000000, 16'd4});
        drive(ONES, ONES, 1'b0);
        drive(TWOS, TWOS, 1'b0);
        drive(ONES, ONES, 1'b0);
        drive(TWOS, {32'h0, 32'h0, 32'h40000000, 32'h40000000}, 1'b1);

        for (int i = 0; i < 8; i++) begin
            vec1(ONES, ONES, 32'h40800000);
            chk("b2b_stall", stall, 32'd0);
        end

        vec1({32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h7FC00001}, ONES, 32'h7FC00000);
        vec1({96'h0, 32'h7F7FFFFF}, {96'h0, 32'h40000000}, 32'h7F800000);
        vec1({32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h00000001}, ONES, 32'h40400000);
        vec1({4{32'h80000000}}, ONES, 32'h80000000);
        vec1({96'h0, 32'h80000000}, ONES, 32'h00000000);
        vec1({64'h0, 32'h33C00000, 32'h3F800000}, {64'h0, 32'h3F800000, 32'h3F800000}, 32'h3F800000);
        vec1({64'h0, 32'hB3C00000, 32'h3F800000}, {64'h0, 32'h3F800000, 32'h3F800000}, 32'h3F7FFFFE);
        vec1({4{32'h3FFFFFFF}}, {96'h0, 32'h3FFFFFFF}, 32'h407FFFFE);

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain1", sb.size(), 32'd0);

        sync();
        out_rdy = 1'b0;
        vec1(ONES, ONES, 32'h40800000);
        n = 0;
        @(negedge clk);
        while (!out_vld && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("hold_seen", {31'd0, out_vld}, 32'd1);
        sb.push_back({32'h41800000, 16'd1});
        in_vld  = 1'b1;
        x_flat  = TWOS;
        y_flat  = TWOS;
        in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("hold_vld", {31'd0, out_vld}, 32'd1);
            chk("hold_z", z, 32'h40800000);
            chk("hold_beats", {16'd0, beats}, 32'd1);
            chk("hold_rdy", {31'd0, in_rdy}, 32'd0);
            @(negedge clk);
        end
        sync();
        out_rdy = 1'b1;
        sync();
        in_vld = 1'b0;

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain2", sb.size(), 32'd0);

        sync();
        drive(TWOS, TWOS, 1'b0);
        drive(TWOS, TWOS, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_vld", {31'd0, out_vld}, 32'd0);
        chk("mid_rst_z", z, 32'd0);
        chk("mid_rst_beats", {16'd0, beats}, 32'd0);
        chk("mid_rst_rdy", {31'd0, in_rdy}, 32'd1);
        sync();
        sync();
        rst = 1'b1;
        vec1(ONES, ONES, 32'h40800000);

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain3", sb.size(), 32'd0);
        repeat (5) @(negedge clk);
        chk("no_stale", {31'd0, out_vld}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
